serial_receiver: RTL

SERIAL_RECEIVER -- requirements
Module: serial_receiver

---
 rtl/serial_pkg.sv | 12 +
 rtl/sync_edge.sv | 31 +++
 rtl/serial_receiver.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state type and default parameters for the serial receiver
package serial_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchronizer with rise/fall detection on the synchronized copy
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/serial_receiver.sv
// rtl/serial_receiver.sv - framed MSB-first serial receiver with overrun and frame-error reporting
module serial_receiver
    import serial_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             sdi,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ack,
    output logic             rx_overrun,
    output logic             rx_frame_err
);

    localparam int               CNT_W       = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(WIDTH - 1);
    localparam logic [1:0]       SETTLE_INIT = 2'(SYNC_STAGES);

    logic w_sclk_s, w_sclk_rise, w_sclk_fall;
    logic w_cs_n_s, w_cs_rise, w_cs_fall;
    logic w_sdi_s, w_sdi_rise, w_sdi_fall;
    logic w_unused;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_async(sclk),
        .o_sync(w_sclk_s), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
        .clk(clk), .rst_n(rst_n), .i_async(cs_n),
        .o_sync(w_cs_n_s), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst_n(rst_n), .i_async(sdi),
        .o_sync(w_sdi_s), .o_rise(w_sdi_rise), .o_fall(w_sdi_fall)
    );

    assign w_unused = ^{w_sclk_s, w_sclk_fall, w_cs_rise, w_cs_fall, w_sdi_rise, w_sdi_fall};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_rx_valid;
    logic             r_overrun;
    logic             r_frame_err;
    logic [1:0]       r_settle;
    logic             r_armed;
    logic             w_shift_en;
    logic             w_word_done;
    logic             w_frame_err;
    logic [WIDTH-1:0] w_shift_nxt;

    // Right after reset the synchronizers still hold their reset idle levels; cs_n
    // must be seen genuinely high before a frame may start, so a mid-word reset
    // cannot resume the old word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_settle <= SETTLE_INIT;
            r_armed  <= 1'b0;
        end else begin
            if (r_settle != 2'd0) begin
                r_settle <= r_settle - 2'd1;
            end
            if (r_settle == 2'd0 && w_cs_n_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_armed && !w_cs_n_s) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_cs_n_s) begin
                    w_state_nxt = IDLE;
                    w_frame_err = (r_cnt != '0);
                end else if (w_sclk_rise) begin
                    w_shift_en = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_shift_nxt = {r_shift[WIDTH-2:0], w_sdi_s};
    assign w_word_done = w_shift_en && (r_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= 1'b0;
            r_frame_err <= w_frame_err;

            if (r_state == IDLE) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (w_shift_en) begin
                r_shift <= w_shift_nxt;
                r_cnt   <= w_word_done ? '0 : r_cnt + CNT_W'(1);
            end

            // A completing word always wins over a same-cycle ack, so the consumer
            // never loses the fresh word; only an unacked old word counts as overrun.
            if (w_word_done) begin
                r_rx_data  <= w_shift_nxt;
                r_rx_valid <= 1'b1;
                r_overrun  <= r_rx_valid && !rx_ack;
            end else if (r_rx_valid && rx_ack) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_overrun   = r_overrun;
    assign rx_frame_err = r_frame_err;

endmodule
